// File: rtl/cam_pixel_capture.sv
// -----------------------------------------------------------------------------
// cam_pixel_capture
//
// Camera front-end stage in front of the Nios camera PIO input port. The raw
// 8-bit camera bus (pclk/href/vsync/data) is oversampled in the system clock
// domain. Pairs of bytes are assembled into RGB565 pixels, and each pixel is
// reduced to RGB555. The block also tracks pixel/line position and frame
// status so that software can pace its reads.
//
// Parameters
//   H_ACTIVE      pixels per line; col saturates at H_ACTIVE-1
//   V_ACTIVE      lines per frame; row saturates at V_ACTIVE-1
//
// Ports
//   clk           system clock; all logic is in this domain
//   reset_n       asynchronous, active-low reset
//   cam_pclk      raw camera pixel clock, sampled as data
//   cam_href      raw line-valid, active-high
//   cam_vsync     raw frame sync, high during vertical blanking
//   cam_data      raw camera byte
//   enable        capture enable; 0 forces IDLE
//   pixel_out     last completed pixel {R[4:0],G[5:1],B[4:0]}
//   pixel_valid   one-clk pulse when pixel_out updates
//   frame_start   one-clk pulse on a vsync falling edge while enabled
//   col           index of the current pixel within its line
//   row           index of the current line within its frame
//   odd_byte_err  sticky: href fell with half a pixel pending; cleared on
//                 frame_start
// -----------------------------------------------------------------------------
module cam_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cam_pclk,
  input  logic        cam_href,
  input  logic        cam_vsync,
  input  logic [7:0]  cam_data,
  input  logic        enable,
  output logic [14:0] pixel_out,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic [9:0]  col,
  output logic [8:0]  row,
  output logic        odd_byte_err
);

  localparam logic [9:0] COL_MAX = 10'(H_ACTIVE - 1);
  localparam logic [8:0] ROW_MAX = 9'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_BYTE_HI,
    S_BYTE_LO
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Synchroniser chains. Index 2 of pclk/vsync is the previous-value flop
  // used for edge detection.
  logic [2:0] r_pclk_sync;
  logic [2:0] r_vs_sync;
  logic [1:0] r_href_sync;
  logic [7:0] r_data_s1;
  logic [7:0] r_data_s2;

  logic [7:0] r_hi;            // high byte of the pixel being assembled
  logic       r_href_prev;     // href as sampled at the previous pclk rise
  logic       r_line_has_pix;  // at least one pixel completed in this line

  logic w_pclk_rise;
  logic w_vs_fall;
  logic w_href;
  logic w_href_fall;
  logic w_restart;
  logic w_latch_hi;
  logic w_pixel_done;
  logic w_odd;
  logic w_line_end;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values, which keeps the synchroniser chains
  // shifting one stage per clock instead of collapsing into a wire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pclk_sync <= '0;
      r_vs_sync   <= '0;
      r_href_sync <= '0;
      r_data_s1   <= '0;
      r_data_s2   <= '0;
    end else begin
      r_pclk_sync <= {r_pclk_sync[1:0], cam_pclk};
      r_vs_sync   <= {r_vs_sync[1:0], cam_vsync};
      r_href_sync <= {r_href_sync[0], cam_href};
      // Data is only consumed in the pclk_rise cycle, when the camera has
      // held it stable for several clks, so a per-bit two-flop chain is safe.
      r_data_s1   <= cam_data;
      r_data_s2   <= r_data_s1;
    end
  end

  assign w_pclk_rise = r_pclk_sync[1] & ~r_pclk_sync[2];
  assign w_vs_fall   = ~r_vs_sync[1] & r_vs_sync[2];
  assign w_href      = r_href_sync[1];
  // href is only meaningful at pclk rises, so its falling edge is detected in
  // that sample stream rather than on the raw oversampled signal.
  assign w_href_fall = w_pclk_rise & ~w_href & r_href_prev;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_restart    = 1'b0;
    w_latch_hi   = 1'b0;
    w_pixel_done = 1'b0;
    w_odd        = 1'b0;
    w_line_end   = 1'b0;

    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_WAIT_FRAME;

        S_WAIT_FRAME: begin
          if (w_vs_fall) begin
            w_restart   = 1'b1;
            w_state_nxt = S_BYTE_HI;
          end
        end

        S_BYTE_HI, S_BYTE_LO: begin
          // A frame restart outranks a coincident byte; the byte is dropped
          // along with any pending high byte.
          if (w_vs_fall) begin
            w_restart   = 1'b1;
            w_state_nxt = S_BYTE_HI;
          end else if (w_pclk_rise) begin
            w_line_end = w_href_fall & r_line_has_pix;
            if (r_state == S_BYTE_HI) begin
              if (w_href) begin
                w_latch_hi  = 1'b1;
                w_state_nxt = S_BYTE_LO;
              end
            end else begin
              if (w_href) w_pixel_done = 1'b1;
              else        w_odd        = 1'b1;
              w_state_nxt = S_BYTE_HI;
            end
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_out      <= '0;
      pixel_valid    <= 1'b0;
      frame_start    <= 1'b0;
      col            <= '0;
      row            <= '0;
      odd_byte_err   <= 1'b0;
      r_hi           <= '0;
      r_href_prev    <= 1'b0;
      r_line_has_pix <= 1'b0;
    end else begin
      pixel_valid <= w_pixel_done;
      frame_start <= w_restart;

      if (w_pclk_rise) r_href_prev <= w_href;

      if (w_restart) begin
        col            <= '0;
        row            <= '0;
        odd_byte_err   <= 1'b0;
        r_line_has_pix <= 1'b0;
      end else begin
        if (w_latch_hi) r_hi <= r_data_s2;

        if (w_pixel_done) begin
          // RGB565 {r_hi, data} -> RGB555: drop the green LSB (data[5]).
          pixel_out      <= {r_hi, r_data_s2[7:6], r_data_s2[4:0]};
          r_line_has_pix <= 1'b1;
          if (col != COL_MAX) col <= col + 10'd1;
        end

        if (w_odd) odd_byte_err <= 1'b1;

        if (w_line_end) begin
          col            <= '0;
          r_line_has_pix <= 1'b0;
          if (row != ROW_MAX) row <= row + 9'd1;
        end
      end
    end
  end

endmodule
